// File: rtl/svo_tmds_out.sv
// TMDS output stage: takes an AXI-stream pixel/control beat and produces three
// DVI 8b/10b symbols (B, G, R) after a fixed two-cycle pipeline.
module svo_tmds_out #(
   parameter int SVO_BITS_PER_PIXEL = 24
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_axis_tvalid,
   output logic                          in_axis_tready,
   input  logic [SVO_BITS_PER_PIXEL-1:0] in_axis_tdata,
   input  logic [3:0]                    in_axis_tuser,
   output logic [9:0]                    tmds_d0,
   output logic [9:0]                    tmds_d1,
   output logic [9:0]                    tmds_d2,
   output logic                          underflow
);

   localparam logic [9:0] IDLE_SYM = 10'b1101010100;

   typedef enum logic {SYNC, RUN} state_t;

   state_t state, state_next;
   logic   accept, take, set_uf;
   logic   b_ctrl, b_hs, b_vs;
   logic [7:0] b_d0, b_d1, b_d2;
   logic [8:0] qm0_c, qm1_c, qm2_c;

   logic       s1_ctrl, s1_hs, s1_vs;
   logic [8:0] s1_qm0, s1_qm1, s1_qm2;
   logic [3:0] s1_n10, s1_n11, s1_n12;
   logic signed [4:0] cnt0, cnt1, cnt2;
   logic [14:0] o0, o1, o2;

   function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
      case (c)
         2'b00:   return 10'b1101010100;
         2'b01:   return 10'b0010101011;
         2'b10:   return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

   // Prefix-XOR gives the XOR chain directly; the XNOR chain differs only by
   // inverting every odd-indexed bit.
   function automatic logic [8:0] tm_qm(input logic [7:0] d);
      logic [3:0] n;
      logic       xn;
      logic [7:0] p;
      n  = 4'($countones(d));
      xn = (n > 4'd4) || (n == 4'd4 && !d[0]);
      p  = d ^ (d << 1);
      p  = p ^ (p << 2);
      p  = p ^ (p << 4);
      return {~xn, p ^ (xn ? 8'hAA : 8'h00)};
   endfunction

   // Returns {next disparity, symbol}; diff is N1-N0 = 2*N1-8.
   function automatic logic [14:0] tm_out(input logic [8:0] qm, input logic [3:0] n1,
                                          input logic signed [4:0] cnt);
      logic signed [4:0] diff, nc;
      logic [9:0]        sym;
      diff = $signed({n1, 1'b0}) - 5'sd8;
      if (cnt == 5'sd0 || diff == 5'sd0) begin
         sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         nc  = qm[8] ? cnt + diff : cnt - diff;
      end else if (cnt[4] == diff[4]) begin
         sym = {1'b1, qm[8], ~qm[7:0]};
         nc  = cnt + (qm[8] ? 5'sd2 : 5'sd0) - diff;
      end else begin
         sym = {1'b0, qm[8], qm[7:0]};
         nc  = cnt + diff - (qm[8] ? 5'sd0 : 5'sd2);
      end
      return {nc, sym};
   endfunction

   always_comb begin
      accept     = in_axis_tvalid & in_axis_tready;
      state_next = state;
      take       = 1'b0;
      set_uf     = 1'b0;
      case (state)
         SYNC: if (accept && in_axis_tuser[0]) begin
            take       = 1'b1;
            state_next = RUN;
         end
         RUN: if (accept) begin
            take = 1'b1;
         end else begin
            set_uf     = 1'b1;
            state_next = SYNC;
         end
         default: state_next = SYNC;
      endcase
      b_ctrl = take ? in_axis_tuser[3] : 1'b1;
      b_hs   = take & in_axis_tuser[1];
      b_vs   = take & in_axis_tuser[2];
      b_d0   = take ? in_axis_tdata[23:16] : '0;
      b_d1   = take ? in_axis_tdata[15:8]  : '0;
      b_d2   = take ? in_axis_tdata[7:0]   : '0;
      qm0_c  = tm_qm(b_d0);
      qm1_c  = tm_qm(b_d1);
      qm2_c  = tm_qm(b_d2);
      o0     = tm_out(s1_qm0, s1_n10, cnt0);
      o1     = tm_out(s1_qm1, s1_n11, cnt1);
      o2     = tm_out(s1_qm2, s1_n12, cnt2);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= SYNC;
         in_axis_tready <= 1'b0;
         underflow      <= 1'b0;
      end else begin
         state          <= state_next;
         in_axis_tready <= 1'b1;
         if (set_uf) underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_ctrl <= 1'b1;
         s1_hs   <= 1'b0;
         s1_vs   <= 1'b0;
         s1_qm0  <= '0;
         s1_qm1  <= '0;
         s1_qm2  <= '0;
         s1_n10  <= '0;
         s1_n11  <= '0;
         s1_n12  <= '0;
      end else begin
         s1_ctrl <= b_ctrl;
         s1_hs   <= b_hs;
         s1_vs   <= b_vs;
         s1_qm0  <= qm0_c;
         s1_qm1  <= qm1_c;
         s1_qm2  <= qm2_c;
         s1_n10  <= 4'($countones(qm0_c[7:0]));
         s1_n11  <= 4'($countones(qm1_c[7:0]));
         s1_n12  <= 4'($countones(qm2_c[7:0]));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt0    <= '0;
         cnt1    <= '0;
         cnt2    <= '0;
         tmds_d0 <= IDLE_SYM;
         tmds_d1 <= IDLE_SYM;
         tmds_d2 <= IDLE_SYM;
      end else if (s1_ctrl) begin
         cnt0    <= '0;
         cnt1    <= '0;
         cnt2    <= '0;
         tmds_d0 <= ctrl_sym({s1_vs, s1_hs});
         tmds_d1 <= ctrl_sym(2'b00);
         tmds_d2 <= ctrl_sym(2'b00);
      end else begin
         {cnt0, tmds_d0} <= o0;
         {cnt1, tmds_d1} <= o1;
         {cnt2, tmds_d2} <= o2;
      end
   end

endmodule

// File: tb/tb_svo_tmds_out.sv
// Bench for svo_tmds_out: directed vector table, then randomized traffic
// checked against a behavioural DVI encoder model.
module tb_svo_tmds_out;

   logic        clk = 1'b0;
   logic        reset, tvalid, tready, uf;
   logic [23:0] tdata;
   logic [3:0]  tuser;
   logic [9:0]  d0, d1, d2;

   always #5 clk = ~clk;

   svo_tmds_out #(.SVO_BITS_PER_PIXEL(24)) dut (
      .clk(clk), .reset(reset), .in_axis_tvalid(tvalid), .in_axis_tready(tready),
      .in_axis_tdata(tdata), .in_axis_tuser(tuser),
      .tmds_d0(d0), .tmds_d1(d1), .tmds_d2(d2), .underflow(uf)
   );

   localparam logic [9:0] IDLE = 10'b1101010100;

   typedef struct {
      logic rst, tv;
      logic [3:0] tu;
      logic [23:0] td;
      logic [9:0] e0, e1, e2;
      logic euf, erdy;
   } vec_t;

   vec_t tbl [20];
   int checks = 0;
   int failures = 0;

   bit         m_run, m_uf, m_rdy, s_ctrl, s_hs, s_vs;
   logic [23:0] s_data;
   int         m_cnt [3];
   logic [9:0] m_out [3];

   function automatic int ones(input logic [7:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 8; i++) if (v[i]) n++;
      return n;
   endfunction

   function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
      logic [9:0] t [4];
      t = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
      return t[c];
   endfunction

   task automatic encode(input logic [7:0] d, input int cin, output logic [9:0] sym, output int cout);
      logic [8:0] qm;
      bit use_xnor;
      int n1, n0, q8;
      use_xnor = (ones(d) > 4) || (ones(d) == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++)
         qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !use_xnor;
      q8 = use_xnor ? 0 : 1;
      n1 = ones(qm[7:0]);
      n0 = 8 - n1;
      if (cin == 0 || n1 == n0) begin
         sym  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         cout = cin + (q8 == 1 ? n1 - n0 : n0 - n1);
      end else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) begin
         sym  = {1'b1, qm[8], ~qm[7:0]};
         cout = cin + 2 * q8 + n0 - n1;
      end else begin
         sym  = {1'b0, qm[8], qm[7:0]};
         cout = cin + n1 - n0 - 2 * (1 - q8);
      end
   endtask

   task automatic model_edge(input logic rst, input logic tv, input logic [3:0] tu, input logic [23:0] td);
      bit take;
      logic [7:0] byt;
      if (rst) begin
         m_run = 0; m_uf = 0; m_rdy = 0;
         s_ctrl = 1; s_hs = 0; s_vs = 0; s_data = '0;
         for (int c = 0; c < 3; c++) begin m_cnt[c] = 0; m_out[c] = IDLE; end
         return;
      end
      if (s_ctrl) begin
         for (int c = 0; c < 3; c++) m_cnt[c] = 0;
         m_out[0] = ctrl_sym({s_vs, s_hs});
         m_out[1] = IDLE;
         m_out[2] = IDLE;
      end else begin
         for (int c = 0; c < 3; c++) begin
            byt = 8'(s_data >> (8 * (2 - c)));
            encode(byt, m_cnt[c], m_out[c], m_cnt[c]);
         end
      end
      take = 0;
      if (!m_run) begin
         if (tv && m_rdy && tu[0]) begin take = 1; m_run = 1; end
      end else if (tv && m_rdy) begin
         take = 1;
      end else begin
         m_uf = 1; m_run = 0;
      end
      s_ctrl = take ? tu[3] : 1'b1;
      s_hs   = take && tu[1];
      s_vs   = take && tu[2];
      s_data = take ? td : '0;
      m_rdy  = 1;
   endtask

   task automatic step(input logic rst, input logic tv, input logic [3:0] tu, input logic [23:0] td);
      reset = rst; tvalid = tv; tuser = tu; tdata = td;
      @(posedge clk);
      model_edge(rst, tv, tu, td);
      #1;
   endtask

   task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_d0"}, d0, m_out[0]);
      chk({tag, "_d1"}, d1, m_out[1]);
      chk({tag, "_d2"}, d2, m_out[2]);
      chk({tag, "_uf"}, 10'(uf), 10'(m_uf));
      chk({tag, "_rdy"}, 10'(tready), 10'(m_rdy));
   endtask

   initial begin
      logic [23:0] pal [6];
      logic [23:0] td;
      logic [3:0]  tu;
      pal = '{24'h000000, 24'hFFFFFF, 24'h0F0F0F, 24'hF0E1D2, 24'h1E2D3C, 24'h808080};

      tbl[0]  = '{1'b1, 1'b0, 4'h0, 24'h000000, IDLE, IDLE, IDLE, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 4'h0, 24'h000000, IDLE, IDLE, IDLE, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 4'h0, 24'h000000, IDLE, IDLE, IDLE, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 4'h8, 24'h123456, IDLE, IDLE, IDLE, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 1'b1, 4'h8, 24'hABCDEF, IDLE, IDLE, IDLE, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 1'b1, 4'h9, 24'h000000, IDLE, IDLE, IDLE, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 4'h0, 24'h000000, IDLE, IDLE, IDLE, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 4'h0, 24'h000000, 10'h100, 10'h100, 10'h100, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 4'hE, 24'h000000, 10'h3FF, 10'h3FF, 10'h3FF, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 4'hA, 24'h000000, 10'h2AB, IDLE, IDLE, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 4'h0, 24'h000000, 10'h0AB, IDLE, IDLE, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 4'h0, 24'h000000, 10'h100, 10'h100, 10'h100, 1'b1, 1'b1};
      tbl[12] = '{1'b0, 1'b1, 4'h0, 24'hFFFFFF, IDLE, IDLE, IDLE, 1'b1, 1'b1};
      tbl[13] = '{1'b0, 1'b1, 4'h0, 24'h000000, IDLE, IDLE, IDLE, 1'b1, 1'b1};
      tbl[14] = '{1'b0, 1'b1, 4'h1, 24'h000000, IDLE, IDLE, IDLE, 1'b1, 1'b1};
      tbl[15] = '{1'b0, 1'b1, 4'h0, 24'h000000, 10'h100, 10'h100, 10'h100, 1'b1, 1'b1};
      tbl[16] = '{1'b0, 1'b1, 4'h0, 24'h000000, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 1'b1};
      tbl[17] = '{1'b1, 1'b1, 4'h0, 24'h000000, IDLE, IDLE, IDLE, 1'b0, 1'b0};
      tbl[18] = '{1'b0, 1'b1, 4'h0, 24'h000000, IDLE, IDLE, IDLE, 1'b0, 1'b1};
      tbl[19] = '{1'b0, 1'b0, 4'h0, 24'h000000, IDLE, IDLE, IDLE, 1'b0, 1'b1};

      for (int i = 0; i < 20; i++) begin
         step(tbl[i].rst, tbl[i].tv, tbl[i].tu, tbl[i].td);
         chk($sformatf("tbl%0d_d0", i), d0, tbl[i].e0);
         chk($sformatf("tbl%0d_d1", i), d1, tbl[i].e1);
         chk($sformatf("tbl%0d_d2", i), d2, tbl[i].e2);
         chk($sformatf("tbl%0d_uf", i), 10'(uf), 10'(tbl[i].euf));
         chk($sformatf("tbl%0d_rdy", i), 10'(tready), 10'(tbl[i].erdy));
      end

      // Long saturated run: disparity must swing but stay bounded.
      step(1'b0, 1'b1, 4'h1, 24'hFFFFFF);
      chk_model("sat0");
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 4'h0, (i % 3 == 0) ? 24'hFFFFFF : 24'hF0F0F0);
         chk_model($sformatf("sat%0d", i + 1));
      end

      for (int i = 0; i < 3000; i++) begin
         td = ($urandom_range(0, 3) == 0) ? pal[$urandom_range(0, 5)] : 24'($urandom);
         tu = 4'($urandom);
         tu[0] = ($urandom_range(0, 24) == 0);
         tu[3] = ($urandom_range(0, 9) < 2);
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) != 0), tu, td);
         chk_model($sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/svo_tmds_out.md
SVO_TMDS_OUT -- requirements
Module: svo_tmds_out

Interface
REQ-001 Parameter SVO_BITS_PER_PIXEL, default 24, pixel width; the block SHALL support only 24 (8 bits each R, G, B).
REQ-002 clk  input  1  sole clock; every register SHALL update on the rising edge.
REQ-003 reset  input  1  one clock; reset is synchronous and active-high.
REQ-004 in_axis_tvalid  input  1  upstream beat valid.
REQ-005 in_axis_tready  output  1  beat accepted when tvalid and tready are both high on a rising edge.
REQ-006 in_axis_tdata  input  24  pixel: [7:0] R, [15:8] G, [23:16] B.
REQ-007 in_axis_tuser  input  4  [0] start of frame, [1] hsync, [2] vsync, [3] blank.
REQ-008 tmds_d0, tmds_d1, tmds_d2  output  10 each  TMDS symbols for the B, G and R channels; bit 0 is transmitted first.
REQ-009 underflow  output  1  sticky flag: the stream starved while in RUN.

Function
REQ-010 The block SHALL have two states, SYNC and RUN, and SHALL hold in_axis_tready=1 in both states.
REQ-011 In SYNC, accepted beats with tuser[0]=0 SHALL be discarded, and an idle beat (control, hsync=0, vsync=0) SHALL enter the pipeline instead.
REQ-012 In SYNC, an accepted beat with tuser[0]=1 SHALL be encoded and SHALL move the state to RUN.
REQ-013 In RUN, each accepted beat SHALL be encoded.
REQ-014 In RUN, a cycle with tvalid=0 SHALL insert an idle beat, set underflow=1 and move the state to SYNC.
REQ-015 Only reset SHALL clear underflow.
REQ-016 Latency SHALL be exactly 2 cycles:
- stage 1 registers control bits, q_m[8:0] and the ones count of q_m[7:0];
- stage 2 updates disparity and registers the output symbol.
REQ-017 A beat whose tuser[3]=1 SHALL produce control symbols with C0=hsync and C1=vsync on tmds_d0, and C0=C1=0 on tmds_d1 and tmds_d2.
- {C1,C0}=00 SHALL give 10'b1101010100.
- 01 SHALL give 10'b0010101011.
- 10 SHALL give 10'b0101010100.
- 11 SHALL give 10'b1010101011.
- Symbols are written bit9..bit0.
REQ-018 A control beat SHALL reset all three disparity counters to 0.
REQ-019 For a beat whose tuser[3]=0, each channel SHALL apply DVI 1.0 8b/10b transition-minimised encoding to its byte D.
- Let n1 be the number of ones in D.
- If n1>4, or n1==4 with D[0]=0, the channel SHALL use XNOR chaining and set q_m[8]=0.
- Otherwise it SHALL use XOR chaining and set q_m[8]=1.
- In both cases q_m[0]=D[0].
REQ-020 Each channel SHALL keep a signed 5-bit disparity cnt, with N1 and N0 the ones and zeros in q_m[7:0].
- If cnt==0 or N1==N0: out={~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}; cnt+=q_m8 ? N1-N0 : N0-N1.
- Else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1): out={1, q_m8, ~q_m[7:0]}; cnt+=2*q_m8+N0-N1.
- Else: out={0, q_m8, q_m[7:0]}; cnt+=N1-N0-2*(~q_m8).
REQ-021 Disparity arithmetic SHALL be signed two's-complement at 5 bits with no saturation; the DVI algorithm bounds it to the range -10..+10.
REQ-022 The three channels SHALL encode in lockstep, and an idle or underflow beat SHALL pass through the same 2-stage pipeline as data.

Reset
REQ-023 While reset=1:
- state SHALL be SYNC;
- pipeline registers SHALL hold idle beats;
- cnt SHALL be 0 on all channels;
- tmds_d0, tmds_d1 and tmds_d2 SHALL equal 10'b1101010100;
- underflow SHALL be 0;
- in_axis_tready SHALL be 0.
REQ-024 in_axis_tready SHALL rise on the first edge after reset deasserts.
REQ-025 Reset asserted mid-frame SHALL take effect on the next edge and SHALL discard all in-flight beats.

Verification
REQ-026 Hold reset, then release it with tvalid=0 -> all channels read 1101010100, tready=1 one cycle after release, underflow=0.
REQ-027 In SYNC, feed beats with tuser=4'b1000, then a beat with tuser=4'b1001 -> earlier beats produce no output change; the SOF beat appears 2 cycles later; state enters RUN.
REQ-028 In RUN with cnt=0, feed two active beats with tdata=24'h000000 -> each channel outputs 10'b0100000000 then 10'b1111111111; cnt goes 0, -8, +2.
REQ-029 Feed blank beats with tuser[2:1]=2'b11 then 2'b01 -> tmds_d0 outputs 1010101011 then 0010101011; d1 and d2 output 1101010100; cnt reads 0 afterwards.
REQ-030 Deassert tvalid for one cycle in RUN -> 2 cycles later an idle symbol 1101010100 appears; underflow=1 and stays 1; the next non-SOF beats are discarded until a SOF beat arrives.
REQ-031 Assert reset during an active line -> on the next edge outputs return to 1101010100, underflow=0 and state is SYNC.
